// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
// Displays a double-buffered {dp,value} image with tear-free frame swaps,
// optional leading-zero blanking and configurable output polarities.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV         = 12500,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_50MHz,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        load,
    input  logic        blank_lz,
    output logic [7:0]  seg,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam int unsigned     CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [7:0]      SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0]      DIGIT_OFF = DIGIT_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [19:0]      shadow_q, shadow_d;    // {dp, value}
    logic [19:0]      pending_q, pending_d;  // {dp, value}
    logic             pending_valid_q, pending_valid_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       digit_q, digit_d;

    logic             tick;
    logic             boundary;
    logic [3:0]       nibble;
    logic [3:0]       zero_ge;
    logic             blanked;
    logic [7:0]       seg_raw;
    logic [3:0]       digit_raw;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Next-state: prescaler, slot index, double buffer and registered display image
    always_comb begin
        cnt_d           = cnt_q;
        idx_d           = idx_q;
        shadow_d        = shadow_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;

        tick     = enable && (cnt_q == CNT_MAX);
        boundary = tick && (idx_q == 2'd3);

        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        if (tick) begin
            idx_d = idx_q + 2'd1;
        end
        frame_done_d = boundary;

        // A load landing on the boundary bypasses pending and swaps in directly.
        if (boundary && load) begin
            shadow_d        = {dp, value};
            pending_valid_d = 1'b0;
        end else if (boundary && pending_valid_q) begin
            shadow_d        = pending_q;
            pending_valid_d = 1'b0;
        end
        if (load && !boundary) begin
            pending_d       = {dp, value};
            pending_valid_d = 1'b1;
        end

        // Display is built from next-cycle slot and shadow so it lines up with idx.
        nibble     = shadow_d[{idx_d, 2'b00} +: 4];
        zero_ge[3] = (shadow_d[15:12] == 4'h0);
        zero_ge[2] = zero_ge[3] && (shadow_d[11:8] == 4'h0);
        zero_ge[1] = zero_ge[2] && (shadow_d[7:4] == 4'h0);
        zero_ge[0] = 1'b0;
        blanked    = blank_lz && zero_ge[idx_d];

        if (!enable) begin
            seg_raw   = '0;
            digit_raw = '0;
        end else begin
            seg_raw   = blanked ? 8'h00 : {shadow_d[16 + idx_d], hex_to_seg(nibble)};
            digit_raw = 4'b0001 << idx_d;
        end
        seg_d   = SEG_ACTIVE_LOW   ? ~seg_raw   : seg_raw;
        digit_d = DIGIT_ACTIVE_LOW ? ~digit_raw : digit_raw;
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk_50MHz) begin
        if (!reset) begin
            cnt_q           <= '0;
            idx_q           <= '0;
            shadow_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            frame_done_q    <= 1'b0;
            seg_q           <= SEG_OFF;
            digit_q         <= DIGIT_OFF;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            shadow_q        <= shadow_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            frame_done_q    <= frame_done_d;
            seg_q           <= seg_d;
            digit_q         <= digit_d;
        end
    end

    assign seg        = seg_q;
    assign digit      = digit_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4 and active-low outputs.
// Sample n is taken on the falling edge following the n-th rising edge after
// reset release; inputs set at sample n are taken by the next rising edge.
module tb_seg7_scan_driver;

    logic        clk_50MHz = 1'b0;
    logic        reset     = 1'b0;
    logic        enable    = 1'b0;
    logic [15:0] value     = '0;
    logic [3:0]  dp        = '0;
    logic        load      = 1'b0;
    logic        blank_lz  = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  digit;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int n      = 0;

    seg7_scan_driver #(
        .SCAN_DIV        (4),
        .SEG_ACTIVE_LOW  (1'b1),
        .DIGIT_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .enable    (enable),
        .value     (value),
        .dp        (dp),
        .load      (load),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .digit     (digit),
        .frame_done(frame_done)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    function automatic logic [3:0] exp_digit(input int unsigned slot);
        case (slot % 4)
            0: return 4'hE;
            1: return 4'hD;
            2: return 4'hB;
            default: return 4'h7;
        endcase
    endfunction

    // advance one clock; load is a one-cycle strobe
    task automatic step();
        @(negedge clk_50MHz);
        n++;
        load = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic do_reset(input logic en, input logic blz);
        @(negedge clk_50MHz);
        reset = 1'b0; load = 1'b0; enable = en; blank_lz = blz;
        repeat (2) @(negedge clk_50MHz);
        reset = 1'b1;
        n = 0;
    endtask

    task automatic test_reset();
        @(negedge clk_50MHz);
        reset = 1'b0; enable = 1'b1; load = 1'b1; value = 16'h8888; dp = 4'hF;
        repeat (3) @(negedge clk_50MHz);
        checks++;
        if (digit !== 4'hF) begin errors++; $display("FAIL reset_digit got %h exp %h", digit, 4'hF); end
        checks++;
        if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h exp %h", seg, 8'hFF); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
        load = 1'b0; reset = 1'b1; n = 0;
        run_to(1);
        checks++;
        if (seg !== 8'hC0 || digit !== 4'hE) begin
            errors++; $display("FAIL reset_first_slot got %h/%h exp E/C0", digit, seg);
        end
        run_to(17);
        checks++;
        if (seg !== 8'hC0) begin errors++; $display("FAIL reset_load_discard got %h exp C0", seg); end
    endtask

    task automatic test_scan();
        do_reset(1'b1, 1'b0);
        for (int i = 1; i <= 33; i++) begin
            run_to(i);
            checks++;
            if (digit !== exp_digit(i / 4) || seg !== 8'hC0 || frame_done !== (i % 16 == 0)) begin
                errors++;
                $display("FAIL scan n=%0d got %h/%h/%b exp %h/C0/%b", i, digit, seg, frame_done,
                         exp_digit(i / 4), (i % 16 == 0));
            end
        end
    endtask

    task automatic test_load();
        do_reset(1'b1, 1'b0);
        run_to(5);
        load = 1'b1; value = 16'h12AF; dp = 4'b0001;
        run_to(6);
        checks++;
        if (seg !== 8'hC0) begin errors++; $display("FAIL load_tearfree n=6 got %h exp C0", seg); end
        run_to(15);
        checks++;
        if (seg !== 8'hC0 || digit !== 4'h7) begin
            errors++; $display("FAIL load_tearfree n=15 got %h/%h exp 7/C0", digit, seg);
        end
        run_to(17);
        checks++;
        if (seg !== 8'h0E || digit !== 4'hE) begin errors++; $display("FAIL load_slot0 got %h/%h exp E/0E", digit, seg); end
        run_to(21);
        checks++;
        if (seg !== 8'h88 || digit !== 4'hD) begin errors++; $display("FAIL load_slot1 got %h/%h exp D/88", digit, seg); end
        run_to(25);
        checks++;
        if (seg !== 8'hA4 || digit !== 4'hB) begin errors++; $display("FAIL load_slot2 got %h/%h exp B/A4", digit, seg); end
        run_to(29);
        checks++;
        if (seg !== 8'hF9 || digit !== 4'h7) begin errors++; $display("FAIL load_slot3 got %h/%h exp 7/F9", digit, seg); end
    endtask

    task automatic test_blank();
        do_reset(1'b1, 1'b1);
        run_to(1);
        load = 1'b1; value = 16'h0050; dp = 4'b0000;
        run_to(5);
        checks++;
        if (seg !== 8'hFF || digit !== 4'hD) begin errors++; $display("FAIL blank_zero_s1 got %h/%h exp D/FF", digit, seg); end
        run_to(17);
        checks++;
        if (seg !== 8'hC0) begin errors++; $display("FAIL blank_s0 got %h exp C0", seg); end
        run_to(21);
        checks++;
        if (seg !== 8'h92) begin errors++; $display("FAIL blank_s1 got %h exp 92", seg); end
        run_to(25);
        checks++;
        if (seg !== 8'hFF) begin errors++; $display("FAIL blank_s2 got %h exp FF", seg); end
        run_to(29);
        checks++;
        if (seg !== 8'hFF || digit !== 4'h7) begin errors++; $display("FAIL blank_s3 got %h/%h exp 7/FF", digit, seg); end
        run_to(30);
        load = 1'b1; value = 16'h0000;
        run_to(33);
        checks++;
        if (seg !== 8'hC0) begin errors++; $display("FAIL blank0_s0 got %h exp C0", seg); end
        run_to(37);
        checks++;
        if (seg !== 8'hFF || digit !== 4'hD) begin errors++; $display("FAIL blank0_s1 got %h/%h exp D/FF", digit, seg); end
        run_to(45);
        checks++;
        if (seg !== 8'hFF || digit !== 4'h7) begin errors++; $display("FAIL blank0_s3 got %h/%h exp 7/FF", digit, seg); end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1, 1'b0);
        run_to(2);
        load = 1'b1; value = 16'h1111; dp = 4'b0000;
        run_to(6);
        load = 1'b1; value = 16'h2222;
        run_to(17);
        checks++;
        if (seg !== 8'hA4) begin errors++; $display("FAIL b2b_latest_s0 got %h exp A4", seg); end
        run_to(21);
        checks++;
        if (seg !== 8'hA4) begin errors++; $display("FAIL b2b_latest_s1 got %h exp A4", seg); end
        run_to(20);
        run_to(20);
        load = 1'b1; value = 16'h4444;
        run_to(31);
        checks++;
        if (seg !== 8'hA4) begin errors++; $display("FAIL b2b_hold got %h exp A4", seg); end
        load = 1'b1; value = 16'h3333;
        run_to(32);
        checks++;
        if (seg !== 8'hB0 || frame_done !== 1'b1) begin
            errors++; $display("FAIL b2b_boundary got %h/%b exp B0/1", seg, frame_done);
        end
        run_to(49);
        checks++;
        if (seg !== 8'hB0) begin errors++; $display("FAIL b2b_no_stale got %h exp B0", seg); end
    endtask

    task automatic test_enable();
        do_reset(1'b1, 1'b0);
        run_to(5);
        enable = 1'b0;
        run_to(6);
        checks++;
        if (seg !== 8'hFF || digit !== 4'hF) begin errors++; $display("FAIL en_dark n=6 got %h/%h exp F/FF", digit, seg); end
        run_to(8);
        load = 1'b1; value = 16'h0007; dp = 4'b0000;
        run_to(15);
        checks++;
        if (seg !== 8'hFF || digit !== 4'hF || frame_done !== 1'b0) begin
            errors++; $display("FAIL en_dark n=15 got %h/%h/%b exp F/FF/0", digit, seg, frame_done);
        end
        enable = 1'b1;
        run_to(17);
        checks++;
        if (digit !== 4'hD || seg !== 8'hC0) begin errors++; $display("FAIL en_resume got %h/%h exp D/C0", digit, seg); end
        run_to(18);
        checks++;
        if (digit !== 4'hB) begin errors++; $display("FAIL en_next_slot got %h exp B", digit); end
        run_to(25);
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL en_fd_early got %b exp 0", frame_done); end
        run_to(26);
        checks++;
        if (frame_done !== 1'b1 || digit !== 4'hE || seg !== 8'hF8) begin
            errors++; $display("FAIL en_frame got %b/%h/%h exp 1/E/F8", frame_done, digit, seg);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b1, 1'b0);
        run_to(1);
        load = 1'b1; value = 16'h1234; dp = 4'b0000;
        run_to(18);
        load = 1'b1; value = 16'h5678;
        run_to(25);
        checks++;
        if (digit !== 4'hB || seg !== 8'hA4) begin errors++; $display("FAIL mrst_pre got %h/%h exp B/A4", digit, seg); end
        reset = 1'b0; load = 1'b1; value = 16'h9999;
        run_to(26);
        checks++;
        if (digit !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0) begin
            errors++; $display("FAIL mrst_dark got %h/%h/%b exp F/FF/0", digit, seg, frame_done);
        end
        reset = 1'b1; n = 0;
        run_to(1);
        checks++;
        if (digit !== 4'hE || seg !== 8'hC0) begin errors++; $display("FAIL mrst_s0 got %h/%h exp E/C0", digit, seg); end
        run_to(5);
        checks++;
        if (digit !== 4'hD || seg !== 8'hC0) begin errors++; $display("FAIL mrst_s1 got %h/%h exp D/C0", digit, seg); end
        run_to(17);
        checks++;
        if (seg !== 8'hC0) begin errors++; $display("FAIL mrst_pending_lost got %h exp C0", seg); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_blank();
        test_back_to_back();
        test_enable();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
